// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt collector.
package irq_pkg;

  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKED = 2'd2
  } irq_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the eligible interrupt sources.
module irq_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] eligible_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    idx_o
);

  // Scanning downwards lets the lowest set index overwrite all others.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        valid_o = 1'b1;
        idx_o   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_collector.sv
// Collects timer irq edges into pending bits and serves them to the CPU by
// fixed priority over a req/ack handshake. IRQ_EVENT_COUNT_EN adds event counters.
//
//   state | meaning
//   IDLE  | no request outstanding, waiting for an eligible pending source
//   REQ   | irq_req high, irq_id frozen, waiting for ack
//   ACKED | pending bit cleared, waiting for ack to return low
module irq_collector
  import irq_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int ID_W    = id_width(NUM_SRC),
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC-1:0]       src_irq,
  input  logic [NUM_SRC-1:0]       mask,
  output logic                     irq_req,
  output logic [ID_W-1:0]          irq_id,
  input  logic                     ack,
  output logic [NUM_SRC-1:0]       overrun,
  input  logic                     clr_overrun,
  output logic [NUM_SRC*CNT_W-1:0] evt_cnt
);

  irq_state_e         state_q, state_d;
  logic               irq_req_q, irq_req_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [NUM_SRC-1:0] src_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] overrun_q, overrun_d;
  logic [NUM_SRC-1:0] rise, clr_vec, eligible, overrun_set;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic               ack_take;

  assign rise     = src_irq & ~src_prev_q;
  assign eligible = pending_q & mask;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .eligible_i (eligible),
    .valid_o    (win_vld),
    .idx_o      (win_id)
  );

  always_comb begin
    state_d   = state_q;
    irq_req_d = irq_req_q;
    irq_id_d  = irq_id_q;
    ack_take  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d   = REQ;
          irq_req_d = 1'b1;
          irq_id_d  = win_id;
        end
      end
      REQ: begin
        if (ack) begin
          ack_take  = 1'b1;
          irq_req_d = 1'b0;
          state_d   = ACKED;
        end
      end
      ACKED: begin
        if (!ack) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        irq_req_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_vec[i] = ack_take && (irq_id_q == ID_W'(i));
    end
  end

  // A rise coinciding with its own clear re-arms pending without flagging overrun.
  assign overrun_set = rise & pending_q & ~clr_vec;
  assign pending_d   = (pending_q & ~clr_vec) | rise;
  assign overrun_d   = (clr_overrun ? '0 : overrun_q) | overrun_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      irq_req_q  <= 1'b0;
      irq_id_q   <= '0;
      src_prev_q <= '1;
      pending_q  <= '0;
      overrun_q  <= '0;
    end else begin
      state_q    <= state_d;
      irq_req_q  <= irq_req_d;
      irq_id_q   <= irq_id_d;
      src_prev_q <= src_irq;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
    end
  end

  assign irq_req = irq_req_q;
  assign irq_id  = irq_id_q;
  assign overrun = overrun_q;

`ifdef IRQ_EVENT_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_SRC];
  logic [CNT_W-1:0] cnt_d [NUM_SRC];

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (clr_overrun) begin
        cnt_d[i] = CNT_W'(rise[i]);
      end else if (rise[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt_out
    assign evt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`else
  assign evt_cnt = '0;
`endif

endmodule

// File: tb/tb_irq_collector.sv
// Scoreboard bench for irq_collector: stimulus pushes expected irq_id values,
// a monitor pops and compares them whenever a new request is presented.
module tb_irq_collector;

  logic        clk;
  logic        reset_n;
  logic [3:0]  src_irq;
  logic [3:0]  mask;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic        ack;
  logic [3:0]  overrun;
  logic        clr_overrun;
  logic [31:0] evt_cnt;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];
  logic [1:0] cur_exp;
  logic       req_prev;

  irq_collector #(
    .NUM_SRC (4),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .src_irq     (src_irq),
    .mask        (mask),
    .irq_req     (irq_req),
    .irq_id      (irq_id),
    .ack         (ack),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .evt_cnt     (evt_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: each new request must match the oldest expected id, and the id
  // must hold its value for as long as the request stays up.
  always @(negedge clk) begin
    if (!reset_n) begin
      req_prev = 1'b0;
    end else begin
      if (irq_req && !req_prev) begin
        if (exp_q.size() == 0) begin
          fail($sformatf("unexpected_req id=%0d", irq_id));
          cur_exp = irq_id;
        end else begin
          cur_exp = exp_q.pop_front();
          chk("req_id", {30'b0, irq_id}, {30'b0, cur_exp});
        end
      end else if (irq_req) begin
        chk("id_stable", {30'b0, irq_id}, {30'b0, cur_exp});
      end
      req_prev = irq_req;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] b);
    src_irq = src_irq | b;
    tick(1);
    src_irq = src_irq & ~b;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!irq_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!irq_req) fail({name, "_timeout"});
  endtask

  task automatic service(input string name);
    wait_req(name);
    @(posedge clk); #1;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    chk({name, "_req_drop"}, {31'b0, irq_req}, 32'd0);
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    src_irq     = 4'b0010;
    mask        = 4'hF;
    ack         = 1'b0;
    clr_overrun = 1'b0;
    #35;
    chk("rst_req", {31'b0, irq_req}, 32'd0);
    chk("rst_id", {30'b0, irq_id}, 32'd0);
    chk("rst_overrun", {28'b0, overrun}, 32'd0);
    chk("rst_evt_cnt", evt_cnt, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Line already high at reset release: no event.
    tick(10);
    chk("held_line_no_req", {31'b0, irq_req}, 32'd0);

    // Single pulse on source 0: request appears after the second edge.
    exp_q.push_back(2'd0);
    pulse(4'b0001);
    @(negedge clk);
    chk("lat_e0_low", {31'b0, irq_req}, 32'd0);
    @(negedge clk);
    chk("lat_e1_high", {31'b0, irq_req}, 32'd1);
    chk("lat_e1_id", {30'b0, irq_id}, 32'd0);
    service("t1");
    src_irq = 4'b0000;
    tick(3);

    // Simultaneous rises on 3 and 1: 1 first, then 3.
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    pulse(4'b1010);
    service("t2a");
    service("t2b");
    tick(10);
    chk("t2_idle", {31'b0, irq_req}, 32'd0);

    // Higher-priority event during REQ does not preempt.
    exp_q.push_back(2'd2);
    pulse(4'b0100);
    wait_req("t3");
    pulse(4'b0001);
    tick(3);
    chk("t3_still_req", {31'b0, irq_req}, 32'd1);
    exp_q.push_back(2'd0);
    service("t3a");
    service("t3b");
    tick(5);

    // Double event on source 1 before ack: overrun, single service.
    exp_q.push_back(2'd1);
    pulse(4'b0010);
    tick(1);
    pulse(4'b0010);
    @(negedge clk);
    chk("t4_overrun", {28'b0, overrun}, 32'h2);
    @(posedge clk); #1;
    src_irq     = 4'b0010;
    clr_overrun = 1'b1;
    tick(1);
    src_irq     = 4'b0000;
    clr_overrun = 1'b0;
    @(negedge clk);
    chk("t4_clr_vs_new_ovr", {28'b0, overrun}, 32'h2);
    @(posedge clk); #1;
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    @(negedge clk);
    chk("t4_ovr_cleared", {28'b0, overrun}, 32'h0);
    service("t4");
    tick(10);
    chk("t4_single_service", {31'b0, irq_req}, 32'd0);

    // Masked source is held pending until unmasked.
    mask = 4'b1110;
    pulse(4'b0001);
    tick(6);
    chk("t5_masked_no_req", {31'b0, irq_req}, 32'd0);
    exp_q.push_back(2'd0);
    mask = 4'hF;
    wait_req("t5");
    chk("t5_req_id", {30'b0, irq_id}, 32'd0);
    service("t5");
    tick(5);

    // Ack held high through ACKED with a new rise on the same source.
    exp_q.push_back(2'd2);
    pulse(4'b0100);
    wait_req("t6");
    @(posedge clk); #1;
    ack = 1'b1;
    tick(1);
    pulse(4'b0100);
    tick(2);
    @(negedge clk);
    chk("t6_no_req_ack_held", {31'b0, irq_req}, 32'd0);
    exp_q.push_back(2'd2);
    @(posedge clk); #1;
    ack = 1'b0;
    service("t6b");
    tick(10);
    chk("t6_idle", {31'b0, irq_req}, 32'd0);

`ifdef IRQ_EVENT_COUNT_EN
    // Saturating counter on source 3.
    mask        = 4'h0;
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    repeat (300) begin
      pulse(4'b1000);
      tick(1);
    end
    @(negedge clk);
    chk("t7_cnt_sat", {24'b0, evt_cnt[31:24]}, 32'd255);
    chk("t7_cnt_others", {8'b0, evt_cnt[23:0]}, 32'd0);
    @(posedge clk); #1;
    src_irq     = 4'b1000;
    clr_overrun = 1'b1;
    tick(1);
    src_irq     = 4'b0000;
    clr_overrun = 1'b0;
    @(negedge clk);
    chk("t7_clr_and_rise", {24'b0, evt_cnt[31:24]}, 32'd1);
    @(posedge clk); #1;
    pulse(4'b1000);
    @(negedge clk);
    chk("t7_cnt_inc", {24'b0, evt_cnt[31:24]}, 32'd2);
`else
    chk("t7_cnt_const0", evt_cnt, 32'd0);
`endif

    tick(2);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
